led_trail_fader: RTL and testbench

Downstream of the 8-bit one-hot LED shift counter. Takes the one-hot position word plus a step strobe and drives 8 LEDs with PWM. The current position is always at full brightness. Previously lit positions fade out in fixed decrements per step, which gives the bouncing light a comet tail. Brightness is double-buffered per PWM frame so duty never changes mid-frame.

---
 rtl/led_trail_fader.sv | 62 ++++++
 tb/tb_led_trail_fader.sv | 105 ++++++++++
 2 files changed

// File: rtl/led_trail_fader.sv
// PWM driver for eight LEDs that trail a one-hot position word: the lit position
// runs at full brightness and earlier positions fade by DECAY on every step strobe.
module led_trail_fader #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DECAY    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  input  logic       step,
  output logic [7:0] led,
  output logic       frame_start
);

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS:0]   DECAY_EXT = (PWM_BITS+1)'(DECAY);
  localparam logic [PWM_BITS-1:0] DECAY_W   = PWM_BITS'(DECAY);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level      [8];
  logic [PWM_BITS-1:0] level_next [8];
  logic [PWM_BITS-1:0] duty       [8];
  logic                frame_end;

  // The position bit overrides a simultaneous step; decay saturates at zero.
  always_comb begin
    frame_end = (pwm_cnt == MAX);
    for (int unsigned i = 0; i < 8; i++) begin
      level_next[i] = level[i];
      if (count[i]) begin
        level_next[i] = MAX;
      end else if (step) begin
        level_next[i] = ({1'b0, level[i]} > DECAY_EXT) ? level[i] - DECAY_W : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt     <= '0;
      frame_start <= 1'b0;
      led         <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        level[i] <= '0;
        duty[i]  <= '0;
      end
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      frame_start <= frame_end;
      for (int unsigned i = 0; i < 8; i++) begin
        level[i] <= level_next[i];
        // Duty takes the level as it stands in the last frame cycle, so an update
        // arriving on that same edge waits one more frame.
        if (frame_end) begin
          duty[i] <= level[i];
        end
        led[i] <= (duty[i] == MAX) || (pwm_cnt < duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader: frame-by-frame LED patterns checked against
// hand-computed duty values for the default 4-bit PWM and DECAY of 4.
module tb_led_trail_fader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count;
  logic       step;
  logic [7:0] led;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_trail_fader #(
    .PWM_BITS(4),
    .DECAY   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .step       (step),
    .led        (led),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles of a frame that begins with pwm_cnt==0. count is c0 before
  // index sw and c1 from sw on; step fires where step_mask is set. d holds the
  // expected duty per LED, one nibble each (LED0 in bits 3:0).
  task automatic run_frame(input string name, input logic [7:0] c0, input logic [7:0] c1,
                           input int sw, input logic [15:0] step_mask,
                           input logic [31:0] d, input int n);
    logic [7:0] e;
    int         di;
    for (int j = 0; j < n; j++) begin
      count = (j < sw) ? c0 : c1;
      step  = step_mask[j];
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        di   = int'(d[4*i +: 4]);
        e[i] = (di == 15) || (j < di);
      end
      check($sformatf("%s led j=%0d", name, j), 32'(led), 32'(e));
      check($sformatf("%s frame_start j=%0d", name, j), 32'(frame_start), 32'(j == 15));
    end
    step = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    count = 8'hFF;
    step  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reset led k=%0d", k), 32'(led), 32'h0);
      check($sformatf("reset frame_start k=%0d", k), 32'(frame_start), 32'h0);
    end
    reset = 1'b0;
    step  = 1'b0;

    // Hold position 0: duty reaches LED0 only from the second frame.
    run_frame("f1_hold",  8'h01, 8'h01, 0, 16'h0000, 32'h0000_0000, 16);
    run_frame("f2_hold",  8'h01, 8'h01, 0, 16'h0000, 32'h0000_000F, 16);
    run_frame("f3_hold",  8'h01, 8'h01, 0, 16'h0000, 32'h0000_000F, 16);

    // Decay tail on LED0 while LED1 is the active position.
    run_frame("f4_tail",  8'h02, 8'h02, 0, 16'h0004, 32'h0000_000F, 16);
    run_frame("f5_tail",  8'h02, 8'h02, 0, 16'h0004, 32'h0000_00FB, 16);
    run_frame("f6_tail",  8'h02, 8'h02, 0, 16'h0004, 32'h0000_00F7, 16);
    run_frame("f7_tail",  8'h02, 8'h02, 0, 16'h0004, 32'h0000_00F3, 16);

    // Step coincides with position 2; three consecutive steps take LED1 15->3.
    run_frame("f8_coll",  8'h04, 8'h04, 0, 16'h001C, 32'h0000_00F0, 16);
    run_frame("f9_coll",  8'h04, 8'h04, 0, 16'h0000, 32'h0000_0F30, 16);

    // LED3 level rises at pwm_cnt=5; duty must wait for the next frame.
    run_frame("f10_buf",  8'h04, 8'h08, 5, 16'h0000, 32'h0000_0F30, 16);
    run_frame("f11_buf",  8'h08, 8'h08, 0, 16'h0004, 32'h0000_FF30, 16);
    run_frame("f12_lvl",  8'h01, 8'h01, 0, 16'h0004, 32'h0000_FB00, 16);

    // Levels 15/11/7 active, reset on the pwm_cnt=9 cycle.
    run_frame("f13_pre",  8'h01, 8'h01, 0, 16'h0000, 32'h0000_B70F, 9);
    reset = 1'b1;
    @(negedge clk);
    check("midreset led", 32'(led), 32'h0);
    check("midreset frame_start", 32'(frame_start), 32'h0);
    reset = 1'b0;
    run_frame("f14_post", 8'h01, 8'h01, 0, 16'h0000, 32'h0000_0000, 16);
    run_frame("f15_post", 8'h01, 8'h01, 0, 16'h0000, 32'h0000_000F, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
